// File: rtl/inst_fetch_unit_if.sv
// rtl/inst_fetch_unit_if.sv - control, memory-port and issue signals of the instruction fetch unit
interface inst_fetch_unit_if #(
    parameter int ADDR_W = 8
);
    logic              run;
    logic              hold;
    logic              jmp_en;
    logic [ADDR_W-1:0] jmp_addr;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rd;
    logic [7:0]        mem_rdata;
    logic              mem_ack;
    logic [7:0]        inst;
    logic              inst_valid;
    logic [ADDR_W-1:0] pc;

    modport master (
        input  run, hold, jmp_en, jmp_addr, mem_rdata, mem_ack,
        output mem_addr, mem_rd, inst, inst_valid, pc
    );

    modport slave (
        output run, hold, jmp_en, jmp_addr, mem_rdata, mem_ack,
        input  mem_addr, mem_rd, inst, inst_valid, pc
    );
endinterface

// File: rtl/inst_fetch_unit.sv
// rtl/inst_fetch_unit.sv - sequential instruction fetch: PC, req/ack memory read, NOP-padded issue
module inst_fetch_unit #(
    parameter int                ADDR_W   = 8,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter logic [7:0]        NOP_OP   = 8'h00
) (
    input logic               clk,
    input logic               rst,
    inst_fetch_unit_if.master bus
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_REQ   = 2'd1;
    localparam logic [1:0] S_ISSUE = 2'd2;

    logic [1:0]        state;
    logic [ADDR_W-1:0] fetch_pc;
    logic              flush;
    logic [ADDR_W-1:0] target;

    // A jump on the same edge that launches a request goes straight to the target.
    assign target = bus.jmp_en ? bus.jmp_addr : fetch_pc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= S_IDLE;
            fetch_pc       <= RESET_PC;
            flush          <= 1'b0;
            bus.mem_addr   <= RESET_PC;
            bus.mem_rd     <= 1'b0;
            bus.inst       <= NOP_OP;
            bus.inst_valid <= 1'b0;
            bus.pc         <= RESET_PC;
        end else begin
            if (bus.jmp_en)
                fetch_pc <= bus.jmp_addr;
            case (state)
                S_IDLE: begin
                    if (bus.run) begin
                        state        <= S_REQ;
                        bus.mem_rd   <= 1'b1;
                        bus.mem_addr <= target;
                    end
                end
                S_REQ: begin
                    if (bus.mem_ack) begin
                        bus.mem_rd <= 1'b0;
                        if (flush || bus.jmp_en) begin
                            // Transaction was overtaken by a jump: drop its data.
                            flush <= 1'b0;
                            state <= S_IDLE;
                        end else begin
                            bus.inst       <= bus.mem_rdata;
                            bus.inst_valid <= 1'b1;
                            bus.pc         <= fetch_pc;
                            fetch_pc       <= fetch_pc + 1'b1;
                            state          <= S_ISSUE;
                        end
                    end else if (bus.jmp_en) begin
                        flush <= 1'b1;
                    end
                end
                S_ISSUE: begin
                    if (!bus.hold) begin
                        bus.inst       <= NOP_OP;
                        bus.inst_valid <= 1'b0;
                        if (bus.run) begin
                            state        <= S_REQ;
                            bus.mem_rd   <= 1'b1;
                            bus.mem_addr <= target;
                        end else begin
                            state <= S_IDLE;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
